// File: rtl/column_tracer_pkg.sv
// Shared types and default constants for the column tracer and its consumers.
package tracer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDivide,
    StEmit,
    StDone
  } state_e;

  localparam int unsigned DefNumCols = 640;
  localparam int unsigned DefDividend = 240;
  localparam int unsigned DefMaxH = 240;

  // Divisor is col+1, pinned at lim once it no longer fits; lim always exceeds the dividend.
  function automatic int unsigned sat_divisor(int unsigned col, int unsigned lim);
    return (col >= lim) ? lim : col + 1;
  endfunction

endpackage

// File: rtl/column_tracer_if.sv
// Result handshake between column_tracer (master) and its consumer (slave).
interface column_tracer_if #(
  parameter int unsigned COL_W = 10,
  parameter int unsigned H_W   = 8
);
  logic             valid;
  logic             ready;
  logic [COL_W-1:0] column;
  logic             side;
  logic [H_W-1:0]   height;

  modport master (output valid, column, side, height, input ready);
  modport slave  (input valid, column, side, height, output ready);
endinterface

// File: rtl/column_tracer_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, H_W cycles per divide.
module seq_divider #(
  parameter int unsigned H_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_start,
  input  logic [H_W-1:0] i_dividend,
  input  logic [H_W:0]   i_divisor,
  output logic           o_busy,
  output logic [H_W-1:0] o_quotient,
  output logic [H_W:0]   o_remainder
);
  localparam int unsigned CntW = $clog2(H_W + 1);

  logic [H_W-1:0]  r_quo;
  logic [H_W:0]    r_rem;
  logic [H_W:0]    r_div;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic [H_W:0]    w_trial;
  logic            w_fit;

  // Partial remainder never exceeds the partial dividend, so its top bit is always zero here.
  assign w_trial = {r_rem[H_W-1:0], r_quo[H_W-1]};
  assign w_fit   = (w_trial >= r_div);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CntW'(H_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_fit ? (w_trial - r_div) : w_trial;
      r_quo  <= {r_quo[H_W-2:0], w_fit};
      r_cnt  <= r_cnt - 1'b1;
      r_busy <= (r_cnt != CntW'(1));
    end
  end

  assign o_busy      = r_busy;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/column_tracer.sv
// Per-column height tracer: height = DIVIDEND / (col+1), clamped, emitted over a valid/ready link.
// Optional macro COLUMN_TRACER_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module column_tracer import tracer_pkg::*; #(
  parameter int unsigned NUM_COLS = DefNumCols,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned H_W      = 8,
  parameter int unsigned DIVIDEND = DefDividend,
  parameter int unsigned MAX_H    = DefMaxH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           start,
  input  logic [H_W-1:0] debug_height,
  output logic           busy,
  output logic           done,
`ifdef COLUMN_TRACER_CYCLE_COUNT_EN
  output logic [15:0]    cycles,
`endif
  column_tracer_if.master res
);
  localparam int unsigned DivW   = H_W + 1;
  localparam int unsigned CntW   = $clog2(H_W + 1);
  localparam int unsigned DivMax = (1 << DivW) - 1;

  state_e          r_state;
  logic [COL_W-1:0] r_col;
  logic [H_W-1:0]  r_dbg_h;
  logic [CntW-1:0] r_cnt;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;

  logic            w_clr;
  logic            w_div_start;
  logic            w_div_busy;
  logic [DivW-1:0] w_divisor;
  logic [H_W-1:0]  w_quo;
  logic [DivW-1:0] w_rem;
  logic [H_W-1:0]  w_height;
  logic            w_side;

  assign w_clr       = reset | ~enable;
  assign w_div_start = (r_state == StLoad) && (debug_height == '0);
  assign w_divisor   = DivW'(sat_divisor(int'(r_col), DivMax));

  seq_divider #(
    .H_W (H_W)
  ) u_div (
    .clk         (clk),
    .reset       (w_clr),
    .i_start     (w_div_start),
    .i_dividend  (H_W'(DIVIDEND)),
    .i_divisor   (w_divisor),
    .o_busy      (w_div_busy),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= StIdle;
      r_col   <= '0;
      r_dbg_h <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state <= StLoad;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StLoad: begin
          r_dbg_h <= debug_height;
          r_cnt   <= CntW'(H_W - 1);
          if (debug_height != '0) begin
            r_state <= StEmit;
            r_valid <= 1'b1;
          end else begin
            r_state <= StDivide;
          end
        end
        StDivide: begin
          // Leaves on the same edge as the divider's last iteration.
          if (r_cnt == '0) begin
            r_state <= StEmit;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StEmit: begin
          if (res.ready) begin
            r_valid <= 1'b0;
            if (r_col == COL_W'(NUM_COLS - 1)) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StLoad;
              r_col   <= r_col + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Result fields come from held registers only, so they stay put while ready is low.
  always_comb begin
    w_height = '0;
    w_side   = 1'b0;
    if (r_valid) begin
      if (r_dbg_h != '0) begin
        w_height = r_dbg_h;
      end else if (w_quo == '0) begin
        w_height = H_W'(1);
      end else begin
        w_height = (int'(w_quo) > MAX_H) ? H_W'(MAX_H) : w_quo;
        w_side   = (w_rem == '0);
      end
    end
  end

  assign res.valid  = r_valid;
  assign res.column = r_col;
  assign res.height = w_height;
  assign res.side   = w_side;
  assign busy       = r_busy | w_div_busy;
  assign done       = r_done;

`ifdef COLUMN_TRACER_CYCLE_COUNT_EN
  logic [15:0] r_cycles;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cycles <= '0;
    end else if (((r_state == StIdle) || (r_state == StDone)) && start) begin
      r_cycles <= '0;
    end else if (r_busy && (r_cycles != 16'hFFFF)) begin
      r_cycles <= r_cycles + 1'b1;
    end
  end

  assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_column_tracer.sv
// Randomized self-checking bench for column_tracer against an arithmetic height model.
module tb_column_tracer;
  localparam int unsigned NumCols  = 640;
  localparam int unsigned ColW     = 10;
  localparam int unsigned HW       = 8;
  localparam int unsigned Dividend = 240;
  localparam int unsigned MaxH     = 240;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          start;
  logic [HW-1:0] debug_height;
  logic          busy;
  logic          done;
`ifdef COLUMN_TRACER_CYCLE_COUNT_EN
  logic [15:0]   cycles;
`endif

  int total = 0;
  int bad   = 0;

  column_tracer_if #(.COL_W(ColW), .H_W(HW)) res_if ();

  column_tracer #(
    .NUM_COLS (NumCols),
    .COL_W    (ColW),
    .H_W      (HW),
    .DIVIDEND (Dividend),
    .MAX_H    (MaxH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .debug_height (debug_height),
    .busy         (busy),
    .done         (done),
`ifdef COLUMN_TRACER_CYCLE_COUNT_EN
    .cycles       (cycles),
`endif
    .res          (res_if)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [HW-1:0] exp_height(int c, int dbg);
    int q;
    if (dbg != 0) return HW'(dbg);
    q = Dividend / (c + 1);
    if (q == 0) return HW'(1);
    if (q > int'(MaxH)) return HW'(MaxH);
    return HW'(q);
  endfunction

  function automatic logic exp_side(int c, int dbg);
    if (dbg != 0) return 1'b0;
    return ((Dividend / (c + 1)) != 0) && ((Dividend % (c + 1)) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic abort_run();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; debug_height = '0; res_if.ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++;
    if (res_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || res_if.column !== '0 ||
        res_if.side !== 1'b0 || res_if.height !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%0b b=%0b d=%0b c=%0d s=%0b h=%0d want all zero",
               res_if.valid, busy, done, res_if.column, res_if.side, res_if.height);
    end
  endtask

  // Runs a full frame; when rand_ready, ready toggles randomly and held results are checked.
  task automatic test_frame(input bit rand_ready, input int dbg);
    int col = 0;
    int guard = 0;
    bit hold = 1'b0;
    logic [ColW-1:0] cv;
    logic [HW-1:0] hv;
    logic sv;
    debug_height = HW'(dbg);
    start = 1'b1; tick(); start = 1'b0;
    while (col < int'(NumCols) && guard < 40000) begin
      if (hold) begin
        total++;
        if (res_if.valid !== 1'b1 || res_if.column !== cv || res_if.height !== hv ||
            res_if.side !== sv) begin
          bad++;
          $display("FAIL hold_stable got v=%0b c=%0d h=%0d s=%0b want v=1 c=%0d h=%0d s=%0b",
                   res_if.valid, res_if.column, res_if.height, res_if.side, cv, hv, sv);
        end
      end
      res_if.ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      hold = res_if.valid && !res_if.ready;
      cv = res_if.column; hv = res_if.height; sv = res_if.side;
      if (res_if.valid && res_if.ready) begin
        total++;
        if (res_if.column !== col[ColW-1:0] || res_if.height !== exp_height(col, dbg) ||
            res_if.side !== exp_side(col, dbg)) begin
          bad++;
          $display("FAIL column_result got c=%0d h=%0d s=%0b want c=%0d h=%0d s=%0b",
                   res_if.column, res_if.height, res_if.side, col, exp_height(col, dbg),
                   exp_side(col, dbg));
        end
        col++;
      end
      tick();
      guard++;
    end
    total++;
    if (guard >= 40000) begin
      bad++;
      $display("FAIL frame_timeout got cols=%0d want %0d", col, NumCols);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || res_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL frame_done got d=%0b b=%0b v=%0b want d=1 b=0 v=0",
               done, busy, res_if.valid);
    end
`ifdef COLUMN_TRACER_CYCLE_COUNT_EN
    if (!rand_ready && dbg == 0) begin
      total++;
      if (cycles !== 16'(NumCols * (HW + 2))) begin
        bad++;
        $display("FAIL cycle_count got %0d want %0d", cycles, NumCols * (HW + 2));
      end
    end
`endif
    repeat (20) begin
      res_if.ready = $urandom_range(1);
      tick();
      total++;
      if (res_if.valid !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL done_hold got v=%0b d=%0b want v=0 d=1", res_if.valid, done);
      end
    end
    debug_height = '0;
  endtask

  task automatic test_hold();
    int n = 0;
    res_if.ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_done got d=%0b b=%0b want d=0 b=1", done, busy);
    end
    while (!(res_if.valid && res_if.column == ColW'(3)) && n < 200) begin
      tick(); n++;
    end
    res_if.ready = 1'b0;
    repeat (5) begin
      tick();
      total++;
      if (res_if.valid !== 1'b1 || res_if.column !== ColW'(3) ||
          res_if.height !== exp_height(3, 0) || res_if.side !== exp_side(3, 0)) begin
        bad++;
        $display("FAIL stall_col3 got v=%0b c=%0d h=%0d s=%0b want v=1 c=3 h=%0d s=%0b",
                 res_if.valid, res_if.column, res_if.height, res_if.side,
                 exp_height(3, 0), exp_side(3, 0));
      end
    end
    res_if.ready = 1'b1;
    tick();
    total++;
    if (res_if.valid !== 1'b0 || res_if.column !== ColW'(4)) begin
      bad++;
      $display("FAIL stall_accept got v=%0b c=%0d want v=0 c=4", res_if.valid, res_if.column);
    end
    abort_run();
  endtask

  task automatic test_enable_drop();
    int n = 0;
    int m = 1;
    res_if.ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    while (!(res_if.valid && res_if.column == ColW'(9)) && n < 300) begin
      tick(); n++;
    end
    tick(); tick(); tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    total++;
    if (res_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || res_if.column !== '0 ||
        res_if.height !== '0) begin
      bad++;
      $display("FAIL enable_drop got v=%0b b=%0b d=%0b c=%0d h=%0d want zeros",
               res_if.valid, busy, done, res_if.column, res_if.height);
    end
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    while (!res_if.valid && n < 40) begin
      tick(); n++;
    end
    total++;
    if (n != int'(HW) + 2 || res_if.column !== '0 || res_if.height !== exp_height(0, 0)) begin
      bad++;
      $display("FAIL start_latency got n=%0d c=%0d h=%0d want n=%0d c=0 h=%0d",
               n, res_if.column, res_if.height, HW + 2, exp_height(0, 0));
    end
    tick();
    while (!res_if.valid && m < 40) begin
      tick(); m++;
    end
    total++;
    if (m != int'(HW) + 2 || res_if.column !== ColW'(1)) begin
      bad++;
      $display("FAIL column_period got m=%0d c=%0d want m=%0d c=1", m, res_if.column, HW + 2);
    end
    abort_run();
  endtask

  task automatic test_debug(input int dbg);
    int n = 1;
    int col = 0;
    int guard = 0;
    debug_height = HW'(dbg);
    res_if.ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    while (!res_if.valid && n < 40) begin
      tick(); n++;
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL debug_latency got %0d want 2", n);
    end
    while (col < 20 && guard < 400) begin
      res_if.ready = ($urandom_range(1) != 0);
      if (res_if.valid && res_if.ready) begin
        total++;
        if (res_if.column !== col[ColW-1:0] || res_if.height !== exp_height(col, dbg) ||
            res_if.side !== 1'b0) begin
          bad++;
          $display("FAIL debug_result got c=%0d h=%0d s=%0b want c=%0d h=%0d s=0",
                   res_if.column, res_if.height, res_if.side, col, dbg);
        end
        col++;
      end
      tick();
      guard++;
    end
    abort_run();
    debug_height = '0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    res_if.ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    while (!res_if.valid && n < 40) begin
      tick(); n++;
    end
    res_if.ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; res_if.ready = 1'b0;
    total++;
    if (res_if.valid !== 1'b0 || busy !== 1'b0 || res_if.column !== '0 ||
        res_if.height !== '0 || res_if.side !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_emit got v=%0b b=%0b c=%0d h=%0d s=%0b want zeros",
               res_if.valid, busy, res_if.column, res_if.height, res_if.side);
    end
    repeat (3) begin
      tick();
      total++;
      if (res_if.valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset got v=%0b b=%0b want 0 0", res_if.valid, busy);
      end
    end
    start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_over_start got b=%0b d=%0b want 0 0", busy, done);
    end
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || res_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_divide got b=%0b v=%0b want 0 0", busy, res_if.valid);
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, 0);
    test_hold();
    test_enable_drop();
    test_debug(100);
    test_debug(int'($urandom_range(255, 1)));
    test_reset_mid();
    test_frame(1'b1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
